// File: rtl/rocc_cmd_issuer_if.sv
// Core-side RoCC link bundle: issue, cmd, resp and writeback channels.
// master = the issuer, slave = the core/accelerator environment.
interface rocc_cmd_issuer_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [6:0]  issue_funct;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_xd;
  logic [31:0] issue_rs1_data;
  logic [31:0] issue_rs2_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_funct;
  logic [4:0]  cmd_rs1;
  logic [4:0]  cmd_rs2;
  logic [4:0]  cmd_rd;
  logic [31:0] cmd_rs1_data;
  logic [31:0] cmd_rs2_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rd_busy;
  logic        idle;
  logic        err_clear;
  logic        timeout_err;
  logic        spurious_err;

  modport master (
    input  issue_valid, issue_funct, issue_rs1, issue_rs2,
    input  issue_rd, issue_xd, issue_rs1_data, issue_rs2_data,
    output issue_ready,
    output cmd_valid, cmd_funct, cmd_rs1, cmd_rs2, cmd_rd,
    output cmd_rs1_data, cmd_rs2_data,
    input  cmd_ready,
    input  resp_valid, resp_rd, resp_data,
    output resp_ready,
    output wb_valid, wb_rd, wb_data,
    input  wb_ready,
    output rd_busy, idle, timeout_err, spurious_err,
    input  err_clear
  );

  modport slave (
    output issue_valid, issue_funct, issue_rs1, issue_rs2,
    output issue_rd, issue_xd, issue_rs1_data, issue_rs2_data,
    input  issue_ready,
    input  cmd_valid, cmd_funct, cmd_rs1, cmd_rs2, cmd_rd,
    input  cmd_rs1_data, cmd_rs2_data,
    output cmd_ready,
    output resp_valid, resp_rd, resp_data,
    input  resp_ready,
    input  wb_valid, wb_rd, wb_data,
    output wb_ready,
    input  rd_busy, idle, timeout_err, spurious_err,
    output err_clear
  );
endinterface

// File: rtl/rocc_cmd_issuer.sv
// Warp RoCC issuer: holds one command, tracks busy rd tags,
// returns writebacks and flags timeouts / spurious responses.
module rocc_cmd_issuer #(
  parameter int MAX_OUTSTANDING = 1,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic rst_n,
  rocc_cmd_issuer_if.master bus
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             cmd_valid_q;
  logic [6:0]       funct_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [4:0]       rd_q;
  logic [31:0]      rs1_data_q;
  logic [31:0]      rs2_data_q;
  logic [31:0]      busy_q;
  logic [31:0]      busy_n;
  logic [31:0]      xd_q;
  logic [CNT_W-1:0] outst_q;
  logic [CNT_W-1:0] outst_n;
  logic [WD_W-1:0]  wd_q;
  logic [WD_W-1:0]  wd_n;
  logic             wb_valid_q;
  logic [4:0]       wb_rd_q;
  logic [31:0]      wb_data_q;
  logic             timeout_q;
  logic             spurious_q;

  logic issue_ready;
  logic resp_ready;
  logic issue_fire;
  logic resp_fire;
  logic resp_hit;
  logic wb_load;
  logic wd_run;
  logic t_set;
  logic s_set;

  always_comb begin
    issue_ready = (!cmd_valid_q || bus.cmd_ready)
                && !busy_q[bus.issue_rd]
                && (outst_q < CNT_W'(MAX_OUTSTANDING))
                && !timeout_q;
    resp_ready  = !wb_valid_q || bus.wb_ready;
    issue_fire  = bus.issue_valid && issue_ready;
    resp_fire   = bus.resp_valid && resp_ready;
    resp_hit    = resp_fire && busy_q[bus.resp_rd];
    s_set       = resp_fire && !busy_q[bus.resp_rd];
    wb_load     = resp_hit && xd_q[bus.resp_rd]
                && (bus.resp_rd != 5'd0);
  end

  // Issue and response never touch the same tag in one cycle:
  // issue needs the bit clear, a hit needs it set.
  always_comb begin
    busy_n = busy_q;
    if (resp_hit)   busy_n[bus.resp_rd]  = 1'b0;
    if (issue_fire) busy_n[bus.issue_rd] = 1'b1;
    outst_n = outst_q;
    unique case (1'b1)
      issue_fire && !resp_hit: outst_n = outst_q + CNT_W'(1);
      resp_hit && !issue_fire: outst_n = outst_q - CNT_W'(1);
      default: outst_n = outst_q;
    endcase
  end

  always_comb begin
    wd_run = (outst_q != '0) && !resp_fire
           && (wd_q != WD_W'(TIMEOUT_CYCLES));
    t_set  = wd_run && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    wd_n   = wd_q;
    if (outst_q == '0 || resp_fire) wd_n = '0;
    else if (wd_run)                wd_n = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid_q <= 1'b0;
      funct_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      busy_q      <= '0;
      xd_q        <= '0;
      outst_q     <= '0;
      wd_q        <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      timeout_q   <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      if (issue_fire) begin
        cmd_valid_q <= 1'b1;
        funct_q     <= bus.issue_funct;
        rs1_q       <= bus.issue_rs1;
        rs2_q       <= bus.issue_rs2;
        rd_q        <= bus.issue_rd;
        rs1_data_q  <= bus.issue_rs1_data;
        rs2_data_q  <= bus.issue_rs2_data;
        xd_q[bus.issue_rd] <= bus.issue_xd;
      end else if (bus.cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end
      busy_q  <= busy_n;
      outst_q <= outst_n;
      wd_q    <= wd_n;
      if (wb_load) begin
        wb_valid_q <= 1'b1;
        wb_rd_q    <= bus.resp_rd;
        wb_data_q  <= bus.resp_data;
      end else if (bus.wb_ready) begin
        wb_valid_q <= 1'b0;
      end
      timeout_q  <= t_set | (timeout_q & !bus.err_clear);
      spurious_q <= s_set | (spurious_q & !bus.err_clear);
    end
  end

  assign bus.issue_ready  = issue_ready;
  assign bus.resp_ready   = resp_ready;
  assign bus.cmd_valid    = cmd_valid_q;
  assign bus.cmd_funct    = funct_q;
  assign bus.cmd_rs1      = rs1_q;
  assign bus.cmd_rs2      = rs2_q;
  assign bus.cmd_rd       = rd_q;
  assign bus.cmd_rs1_data = rs1_data_q;
  assign bus.cmd_rs2_data = rs2_data_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.rd_busy      = busy_q;
  assign bus.idle         = !cmd_valid_q && (outst_q == '0)
                          && !wb_valid_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.spurious_err = spurious_q;
endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Directed bench for rocc_cmd_issuer: the bench plays both the
// core and the accelerator, with hand-computed expectations.
module tb_rocc_cmd_issuer;
  localparam logic [6:0] GET_STATUS = 7'h01;
  localparam logic [6:0] SET_MASK   = 7'h02;
  localparam logic [6:0] LOAD_CFG   = 7'h03;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  rocc_cmd_issuer_if bus();

  rocc_cmd_issuer #(
    .MAX_OUTSTANDING(1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [6:0] f,
                             input logic [4:0] rd,
                             input logic xd,
                             input logic [31:0] d1,
                             input logic [31:0] d2);
    bus.issue_valid    = 1'b1;
    bus.issue_funct    = f;
    bus.issue_rs1      = 5'd1;
    bus.issue_rs2      = 5'd2;
    bus.issue_rd       = rd;
    bus.issue_xd       = xd;
    bus.issue_rs1_data = d1;
    bus.issue_rs2_data = d2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_funct = '0;
    bus.issue_rs1 = '0;
    bus.issue_rs2 = '0;
    bus.issue_rd = '0;
    bus.issue_xd = 1'b0;
    bus.issue_rs1_data = '0;
    bus.issue_rs2_data = '0;
    bus.cmd_ready = 1'b1;
    bus.resp_valid = 1'b0;
    bus.resp_rd = '0;
    bus.resp_data = '0;
    bus.wb_ready = 1'b1;
    bus.err_clear = 1'b0;
    tick();
    tick();
    total++;
    if ({bus.cmd_valid, bus.wb_valid, bus.timeout_err,
         bus.spurious_err} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=0000",
               {bus.cmd_valid, bus.wb_valid,
                bus.timeout_err, bus.spurious_err});
    end
    total++;
    if ({bus.cmd_funct, bus.cmd_rd, bus.cmd_rs1_data,
         bus.wb_rd, bus.wb_data} !== '0) begin
      bad++;
      $display("FAIL reset_fields got=%h/%h/%h/%h/%h exp=0",
               bus.cmd_funct, bus.cmd_rd, bus.cmd_rs1_data,
               bus.wb_rd, bus.wb_data);
    end
    total++;
    if (bus.rd_busy !== 32'h0) begin
      bad++;
      $display("FAIL reset_busy got=%h exp=0", bus.rd_busy);
    end
    total++;
    if ({bus.idle, bus.resp_ready, bus.issue_ready} !== 3'b111) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=111",
               {bus.idle, bus.resp_ready, bus.issue_ready});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_get_status();
    drive_issue(GET_STATUS, 5'd5, 1'b1, 32'h11, 32'h22);
    #1;
    total++;
    if (bus.issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL gs_issue_ready got=%b exp=1", bus.issue_ready);
    end
    tick();
    bus.issue_valid = 1'b0;
    total++;
    if ({bus.cmd_valid, bus.cmd_funct, bus.cmd_rd, bus.cmd_rs1,
         bus.cmd_rs2} !== {1'b1, GET_STATUS, 5'd5, 5'd1, 5'd2}) begin
      bad++;
      $display("FAIL gs_cmd got=%b/%h/%0d exp=1/01/5",
               bus.cmd_valid, bus.cmd_funct, bus.cmd_rd);
    end
    total++;
    if (bus.rd_busy !== 32'h20 || bus.idle !== 1'b0) begin
      bad++;
      $display("FAIL gs_busy got=%h idle=%b exp=20 idle=0",
               bus.rd_busy, bus.idle);
    end
    tick();
    total++;
    if (bus.cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL gs_cmd_drop got=%b exp=0", bus.cmd_valid);
    end
    bus.resp_valid = 1'b1;
    bus.resp_rd = 5'd5;
    bus.resp_data = 32'h0000_0021;
    tick();
    bus.resp_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data}
        !== {1'b1, 5'd5, 32'h21}) begin
      bad++;
      $display("FAIL gs_wb got=%b/%0d/%h exp=1/5/00000021",
               bus.wb_valid, bus.wb_rd, bus.wb_data);
    end
    total++;
    if (bus.rd_busy !== 32'h0) begin
      bad++;
      $display("FAIL gs_busy_clr got=%h exp=0", bus.rd_busy);
    end
    tick();
    total++;
    if (bus.wb_valid !== 1'b0 || bus.idle !== 1'b1) begin
      bad++;
      $display("FAIL gs_idle got=wb%b idle%b exp=wb0 idle1",
               bus.wb_valid, bus.idle);
    end
  endtask

  task automatic test_max_outstanding();
    drive_issue(GET_STATUS, 5'd3, 1'b1, 32'h0, 32'h0);
    tick();
    bus.issue_valid = 1'b0;
    tick();
    drive_issue(SET_MASK, 5'd4, 1'b0, 32'h5, 32'h6);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (bus.issue_ready !== 1'b0) begin
        bad++;
        $display("FAIL mo_blocked cyc=%0d got=%b exp=0",
                 i, bus.issue_ready);
      end
      tick();
    end
    bus.resp_valid = 1'b1;
    bus.resp_rd = 5'd3;
    bus.resp_data = 32'hAB;
    #1;
    total++;
    if (bus.issue_ready !== 1'b0) begin
      bad++;
      $display("FAIL mo_resp_cycle got=%b exp=0", bus.issue_ready);
    end
    tick();
    bus.resp_valid = 1'b0;
    #1;
    total++;
    if (bus.issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL mo_unblock got=%b exp=1", bus.issue_ready);
    end
    tick();
    bus.issue_valid = 1'b0;
    total++;
    if (bus.cmd_valid !== 1'b1 || bus.cmd_rd !== 5'd4
        || bus.rd_busy !== 32'h10) begin
      bad++;
      $display("FAIL mo_rd4 got=%b/%0d/%h exp=1/4/00000010",
               bus.cmd_valid, bus.cmd_rd, bus.rd_busy);
    end
    tick();
    bus.resp_valid = 1'b1;
    bus.resp_rd = 5'd4;
    bus.resp_data = 32'h0;
    tick();
    bus.resp_valid = 1'b0;
    tick();
    total++;
    if (bus.idle !== 1'b1 || bus.spurious_err !== 1'b0) begin
      bad++;
      $display("FAIL mo_drain got=idle%b sp%b exp=idle1 sp0",
               bus.idle, bus.spurious_err);
    end
  endtask

  task automatic test_cmd_hold();
    bus.cmd_ready = 1'b0;
    drive_issue(LOAD_CFG, 5'd6, 1'b0, 32'h8000_1000, 32'h40);
    tick();
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.cmd_valid, bus.cmd_funct, bus.cmd_rd,
           bus.cmd_rs1_data, bus.cmd_rs2_data}
          !== {1'b1, LOAD_CFG, 5'd6, 32'h8000_1000, 32'h40}) begin
        bad++;
        $display("FAIL hold cyc=%0d got=%b/%0d/%h/%h exp=1/6/80001000/40",
                 i, bus.cmd_valid, bus.cmd_rd,
                 bus.cmd_rs1_data, bus.cmd_rs2_data);
      end
      tick();
    end
    bus.cmd_ready = 1'b1;
    total++;
    if (bus.cmd_valid !== 1'b1
        || bus.cmd_rs1_data !== 32'h8000_1000) begin
      bad++;
      $display("FAIL hold_6th got=%b/%h exp=1/80001000",
               bus.cmd_valid, bus.cmd_rs1_data);
    end
    tick();
    total++;
    if (bus.cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_once got=%b exp=0", bus.cmd_valid);
    end
    bus.resp_valid = 1'b1;
    bus.resp_rd = 5'd6;
    bus.resp_data = 32'h7;
    tick();
    bus.resp_valid = 1'b0;
    tick();
  endtask

  task automatic test_no_xd();
    drive_issue(SET_MASK, 5'd7, 1'b0, 32'hF, 32'h0);
    tick();
    bus.issue_valid = 1'b0;
    total++;
    if (bus.rd_busy !== 32'h80) begin
      bad++;
      $display("FAIL noxd_busy got=%h exp=00000080", bus.rd_busy);
    end
    tick();
    bus.resp_valid = 1'b1;
    bus.resp_rd = 5'd7;
    bus.resp_data = 32'h0;
    tick();
    bus.resp_valid = 1'b0;
    total++;
    if (bus.wb_valid !== 1'b0 || bus.rd_busy !== 32'h0) begin
      bad++;
      $display("FAIL noxd_wb got=wb%b busy=%h exp=wb0 busy=0",
               bus.wb_valid, bus.rd_busy);
    end
    total++;
    if (bus.idle !== 1'b1 || bus.issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL noxd_outst got=idle%b rdy%b exp=1 1",
               bus.idle, bus.issue_ready);
    end
  endtask

  task automatic test_spurious();
    bus.resp_valid = 1'b1;
    bus.resp_rd = 5'd9;
    bus.resp_data = 32'hDEAD;
    tick();
    bus.resp_valid = 1'b0;
    total++;
    if (bus.spurious_err !== 1'b1 || bus.wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL spur_set got=sp%b wb%b exp=sp1 wb0",
               bus.spurious_err, bus.wb_valid);
    end
    tick();
    total++;
    if (bus.spurious_err !== 1'b1) begin
      bad++;
      $display("FAIL spur_sticky got=%b exp=1", bus.spurious_err);
    end
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    total++;
    if (bus.spurious_err !== 1'b0) begin
      bad++;
      $display("FAIL spur_clear got=%b exp=0", bus.spurious_err);
    end
  endtask

  task automatic test_timeout();
    drive_issue(GET_STATUS, 5'd10, 1'b1, 32'h0, 32'h0);
    tick();
    bus.issue_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_early got=%b exp=0", bus.timeout_err);
    end
    tick();
    total++;
    if (bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_set got=%b exp=1", bus.timeout_err);
    end
    bus.resp_valid = 1'b1;
    bus.resp_rd = 5'd10;
    bus.resp_data = 32'h1234;
    tick();
    bus.resp_valid = 1'b0;
    total++;
    if ({bus.wb_valid, bus.wb_rd, bus.wb_data, bus.rd_busy}
        !== {1'b1, 5'd10, 32'h1234, 32'h0}) begin
      bad++;
      $display("FAIL to_late got=%b/%0d/%h/%h exp=1/10/1234/0",
               bus.wb_valid, bus.wb_rd, bus.wb_data, bus.rd_busy);
    end
    tick();
    drive_issue(SET_MASK, 5'd11, 1'b0, 32'h0, 32'h0);
    #1;
    total++;
    if (bus.issue_ready !== 1'b0 || bus.timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL to_block got=rdy%b to%b exp=rdy0 to1",
               bus.issue_ready, bus.timeout_err);
    end
    bus.issue_valid = 1'b0;
    bus.err_clear = 1'b1;
    tick();
    bus.err_clear = 1'b0;
    #1;
    total++;
    if (bus.timeout_err !== 1'b0 || bus.issue_ready !== 1'b1) begin
      bad++;
      $display("FAIL to_clear got=to%b rdy%b exp=to0 rdy1",
               bus.timeout_err, bus.issue_ready);
    end
  endtask

  task automatic test_reset_mid();
    drive_issue(GET_STATUS, 5'd12, 1'b1, 32'h0, 32'h0);
    tick();
    bus.issue_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.rd_busy !== 32'h0 || bus.cmd_valid !== 1'b0
        || bus.idle !== 1'b1) begin
      bad++;
      $display("FAIL rmid_state got=%h/%b/%b exp=0/0/1",
               bus.rd_busy, bus.cmd_valid, bus.idle);
    end
    tick();
    rst_n = 1'b1;
    bus.resp_valid = 1'b1;
    bus.resp_rd = 5'd12;
    bus.resp_data = 32'h55;
    tick();
    bus.resp_valid = 1'b0;
    total++;
    if (bus.spurious_err !== 1'b1 || bus.wb_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_spur got=sp%b wb%b exp=sp1 wb0",
               bus.spurious_err, bus.wb_valid);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    test_reset();
    test_get_status();
    test_max_outstanding();
    test_cmd_hold();
    test_no_xd();
    test_spurious();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rocc_cmd_issuer.md
Name: rocc_cmd_issuer

Overview:
- Core-side initiator of the Warp RoCC link.
- Accepts custom instructions from the scalar core's execute stage and drives the accelerator's cmd channel (funct/rs1/rs2/rd/rs1_data/rs2_data, valid/ready).
- Collects accelerator responses and returns register writebacks to the core.
- Maintains a per-rd busy scoreboard, an outstanding-command limit and a response timeout watchdog.

Parameters:
- MAX_OUTSTANDING, 1, max commands issued but not yet responded to (1..31).
- TIMEOUT_CYCLES, 4096, cycles with outstanding>0 and no accepted response before timeout_err sets.
- CNT_W, $clog2(MAX_OUTSTANDING+1), outstanding counter width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  core presents a custom instruction
- issue_ready  out  1  issuer accepts instruction this cycle
- issue_funct  in  7  opcode (warp_pkg rocc_opcode_e encoding)
- issue_rs1  in  5  source register index 1
- issue_rs2  in  5  source register index 2
- issue_rd  in  5  destination register / response tag
- issue_xd  in  1  1 = core expects writeback
- issue_rs1_data  in  32  rs1 value
- issue_rs2_data  in  32  rs2 value
- cmd_valid  out  1  command to accelerator
- cmd_ready  in  1  accelerator accepts
- cmd_funct  out  7  registered funct
- cmd_rs1  out  5  registered rs1
- cmd_rs2  out  5  registered rs2
- cmd_rd  out  5  registered rd
- cmd_rs1_data  out  32  registered rs1 data
- cmd_rs2_data  out  32  registered rs2 data
- resp_valid  in  1  accelerator response
- resp_ready  out  1  issuer accepts response
- resp_rd  in  5  response tag
- resp_data  in  32  response data
- wb_valid  out  1  writeback to core regfile
- wb_ready  in  1  core accepts writeback
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- rd_busy  out  32  scoreboard, bit i = rd i outstanding
- idle  out  1  no held command, outstanding==0, no pending wb
- err_clear  in  1  clears sticky errors
- timeout_err  out  1  sticky watchdog error
- spurious_err  out  1  sticky: response to non-busy tag

Behaviour:
- Reset: cmd_valid=0, all cmd_* fields=0, resp_ready=1, wb_valid=0, wb_rd=0, wb_data=0, rd_busy=0, idle=1, timeout_err=0, spurious_err=0. Outstanding count=0, watchdog=0, xd tags=0.
- Command holding register (1 entry):
  - issue_ready = (!cmd_valid || cmd_ready) && !rd_busy[issue_rd] && (outstanding < MAX_OUTSTANDING) && !timeout_err.
  - On issue_valid && issue_ready: capture all fields; cmd_valid=1 the next cycle. Latency issue->cmd_valid: 1 cycle.
  - cmd_* hold stable while cmd_valid && !cmd_ready.
  - cmd_valid clears after the handshake unless a new issue is accepted in the same cycle (back-to-back issue allowed).
- Scoreboard:
  - On issue accept: rd_busy[issue_rd]<=1, xd_tag[issue_rd]<=issue_xd, outstanding+1.
  - Hazard check uses registered rd_busy, so same-cycle clear-then-set of the same rd never occurs.
  - rd=0 is tracked like any other tag.
- Response path:
  - resp_ready = !wb_valid || wb_ready.
  - On resp_valid && resp_ready with rd_busy[resp_rd]=1: clear busy bit, outstanding-1.
  - If xd_tag[resp_rd] && resp_rd!=0: wb_valid<=1, wb_rd<=resp_rd, wb_data<=resp_data (1-cycle latency). Otherwise the response is dropped silently.
  - Response to a non-busy tag: accepted, dropped, spurious_err<=1, no count change.
  - Simultaneous issue accept and valid response: outstanding unchanged; both busy-bit updates apply (different tags).
  - wb_valid clears on wb_ready unless a new writeback loads the same cycle.
- Watchdog:
  - Counts while outstanding>0.
  - Resets to 0 on any accepted response or when outstanding==0.
  - On reaching TIMEOUT_CYCLES: timeout_err<=1, counter saturates.
  - timeout_err blocks new issues; responses are still drained.
- err_clear: clears both sticky flags next cycle. If a set condition occurs in the same cycle, set wins.
- idle = !cmd_valid && outstanding==0 && !wb_valid (combinational from regs). The core uses it for fence.
- Reset mid-operation: all state returns to reset values immediately; in-flight responses after reset are treated as spurious.

Test Plan:
- Issue funct=GET_STATUS, rd=5, xd=1; accelerator returns resp_rd=5, data=0x0000_0021 -> cmd_valid 1 cycle after issue; wb_valid, wb_rd=5, wb_data=0x21 one cycle after resp handshake; rd_busy=0; idle=1.
- MAX_OUTSTANDING=1, issue rd=3, then try rd=4 before response -> issue_ready=0 until resp_rd=3 accepted; rd=4 issues the following cycle.
- Hold cmd_ready=0 for 5 cycles with rs1_data=0x8000_1000, rs2_data=0x40 -> cmd_* stable throughout; single handshake on the 6th cycle.
- Issue SET_MASK rd=7 xd=0, response data=0 -> no wb_valid; rd_busy[7] cleared; outstanding=0.
- Inject resp_valid with resp_rd=9 while nothing is busy -> spurious_err=1, no wb; err_clear -> 0 next cycle.
- TIMEOUT_CYCLES=16, issue and withhold the response -> timeout_err=1 exactly 16 cycles after outstanding became 1; issue_ready=0; a late response still clears busy and produces a writeback.
